game_flow_controller: RTL
=========================

Name: game_flow_controller

Overview:
Parametrised successor to the single-level game state controller. Sequences a multi-level run with a lives budget, pause/resume, timed respawn and timed level-transition phases, plus win and game-over endings. Sits between the keyboard keycode path and the sprite/level/render blocks. Drives the encoded game state, current level, remaining lives and one-cycle event strobes.

Parameters:
NUM_LEVELS, 3, number of levels; legal range >=1; final level index is NUM_LEVELS-1
LIVES_INIT, 3, lives at run start; legal range 1..15
RESPAWN_CYCLES, 120, RESPAWN phase length in Clk cycles; minimum 1
TRANSITION_CYCLES, 240, LEVEL_XFER phase length in Clk cycles; minimum 1
KEY_PAUSE, 8'h29, keycode that toggles pause

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-low reset
keycode  in  8  current keyboard keycode; 0 = no key pressed
playerDead  in  1  level-sensitive: player killed this cycle
levelComplete  in  1  level-sensitive: level goal reached this cycle
gameState  out  3  START=0, PLAY=1, PAUSE=2, RESPAWN=3, LEVEL_XFER=4, GAMEOVER=5, WIN=6
level  out  $clog2(NUM_LEVELS+1)  current level index
lives  out  4  remaining lives
respawnPulse  out  1  1-cycle strobe on RESPAWN->PLAY
levelStartPulse  out  1  1-cycle strobe whenever a level begins

Behaviour:
- Reset low: state=START, level=0, lives=LIVES_INIT, timer=0, keycode_q=0, both pulses 0. Reset is asynchronous; assertion mid-phase aborts that phase immediately.
- keyPress = (keycode!=0) && (keycode_q==0). keycode_q is keycode registered each cycle. A held key produces exactly one press. A change between two nonzero codes is not a press.
- gameState is decoded directly from the state register. No additional latency. All transitions take effect on the next Clk edge.
- START: on keyPress (any code) -> PLAY; set lives=LIVES_INIT, level=0; levelStartPulse=1 for the following cycle.
- PLAY: priority is playerDead > levelComplete > pause press.
  - playerDead with lives==1 -> GAMEOVER, lives=0.
  - playerDead with lives>1 -> RESPAWN; lives-1; timer=RESPAWN_CYCLES-1.
  - levelComplete with level==NUM_LEVELS-1 -> WIN.
  - levelComplete otherwise -> LEVEL_XFER; timer=TRANSITION_CYCLES-1.
  - keyPress with keycode==KEY_PAUSE -> PAUSE. Any other keycode is ignored.
- PAUSE: keyPress with KEY_PAUSE -> PLAY. playerDead, levelComplete and all other keys are ignored.
- RESPAWN: timer decrements each cycle. Timer==0 -> PLAY with respawnPulse. Deaths, level completion and key presses are all ignored.
- LEVEL_XFER: timer decrements each cycle. Timer==0 -> PLAY; level+1; levelStartPulse. All inputs are ignored.
- Phase lengths: RESPAWN and LEVEL_XFER each last exactly their *_CYCLES parameter in cycles, counted from the entry edge to the exit edge. A value of 1 gives a single-cycle phase.
- GAMEOVER: keyPress (any) -> PLAY; lives=LIVES_INIT, level=0; levelStartPulse.
- WIN: keyPress (any) -> START.
- Width rules:
  - Timer width = $clog2(max(RESPAWN_CYCLES,TRANSITION_CYCLES)).
  - lives never underflows below 0.
  - level never exceeds NUM_LEVELS-1.
- Illegal state encodings (7) recover to START on the next edge.
- Pulses are registered and are never high in the same cycle as each other.

Decomposition:
- Package game_pkg holds:
  - the game_state_t enum, logic[2:0], with the encodings above;
  - the KEY_PAUSE default constant;
  - the LIVES_W=4 constant.
- The render and sprite blocks import game_state_t from game_pkg, not raw literals.
- One natural sub-module: key_press_detect (Clk, Reset, keycode -> keyPress, pressCode). It holds the keycode_q register and the edge logic.
- The countdown timer stays inline.

Test Plan:
- Reset low then high, keycode=0 -> gameState=0, lives=3, level=0. Then keycode=8'h04 for 5 cycles -> gameState=1 after 1 edge; exactly one levelStartPulse; stays PLAY while held.
- In PLAY with RESPAWN_CYCLES=4: playerDead for 1 cycle -> gameState=3, lives=2. gameState=3 for exactly 4 cycles, then 1 with respawnPulse=1 for 1 cycle. A second playerDead asserted during RESPAWN has no effect.
- Three deaths from lives=3 -> final gameState=5, lives=0. Then keycode 8'h2C pressed -> gameState=1, lives=3, level=0.
- With TRANSITION_CYCLES=2: levelComplete at level 0 -> LEVEL_XFER for 2 cycles -> PLAY, level=1. Repeat -> level=2. levelComplete at level 2 -> gameState=6. Key press -> gameState=0.
- In PLAY: press 8'h29 -> PAUSE. playerDead and levelComplete asserted -> no change. Hold 8'h29 -> still PAUSE. Release and press again -> PLAY with lives unchanged.
- Simultaneous playerDead, levelComplete and pause press in PLAY -> RESPAWN, lives-1, level unchanged. Reset asserted low mid-LEVEL_XFER -> immediately START, level=0, lives=3, pulses 0.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the game flow controller and the blocks that consume its state.
package game_pkg;

  typedef enum logic [2:0] {
    ST_START      = 3'd0,
    ST_PLAY       = 3'd1,
    ST_PAUSE      = 3'd2,
    ST_RESPAWN    = 3'd3,
    ST_LEVEL_XFER = 3'd4,
    ST_GAMEOVER   = 3'd5,
    ST_WIN        = 3'd6
  } game_state_t;

  localparam logic [7:0] KEY_PAUSE = 8'h29;
  localparam int         LIVES_W   = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/game_flow_controller_key_press_detect.sv
// Turns the raw keycode into a single-cycle press: a fresh nonzero code after an idle (zero) cycle.
module key_press_detect (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  output logic       keyPress,
  output logic [7:0] pressCode
);

  logic [7:0] keycode_q_r;

  // Previous-cycle keycode, used to suppress repeats while a key is held
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      keycode_q_r <= 8'h00;
    end else begin
      keycode_q_r <= keycode;
    end
  end

  // A switch between two nonzero codes is deliberately not a press
  always_comb begin
    keyPress  = (keycode != 8'h00) && (keycode_q_r == 8'h00);
    pressCode = keycode;
  end

endmodule

// File: rtl/game_flow_controller.sv
// Multi-level run sequencer: lives budget, pause, timed respawn and level transitions, win/game-over.
module game_flow_controller
  import game_pkg::*;
#(
  parameter int         NUM_LEVELS        = 3,
  parameter int         LIVES_INIT        = 3,
  parameter int         RESPAWN_CYCLES    = 120,
  parameter int         TRANSITION_CYCLES = 240,
  parameter logic [7:0] KEY_PAUSE         = game_pkg::KEY_PAUSE
) (
  input  logic                              Clk,
  input  logic                              Reset,
  input  logic [7:0]                        keycode,
  input  logic                              playerDead,
  input  logic                              levelComplete,
  output logic [2:0]                        gameState,
  output logic [$clog2(NUM_LEVELS+1)-1:0]   level,
  output logic [3:0]                        lives,
  output logic                              respawnPulse,
  output logic                              levelStartPulse
);

  localparam int LEVEL_W  = $clog2(NUM_LEVELS + 1);
  localparam int TIMER_RAW = $clog2(max_int(RESPAWN_CYCLES, TRANSITION_CYCLES));
  localparam int TIMER_W  = (TIMER_RAW < 1) ? 1 : TIMER_RAW;

  localparam logic [LEVEL_W-1:0] LAST_LEVEL   = LEVEL_W'(NUM_LEVELS - 1);
  localparam logic [LIVES_W-1:0] LIVES_START  = LIVES_W'(LIVES_INIT);
  localparam logic [TIMER_W-1:0] RESPAWN_LOAD = TIMER_W'(RESPAWN_CYCLES - 1);
  localparam logic [TIMER_W-1:0] XFER_LOAD    = TIMER_W'(TRANSITION_CYCLES - 1);

  game_state_t        state_r;
  logic [TIMER_W-1:0] timer_r;
  logic               key_press_s;
  logic [7:0]         press_code_s;
  logic               pause_press_s;

  key_press_detect u_key (
    .Clk       (Clk),
    .Reset     (Reset),
    .keycode   (keycode),
    .keyPress  (key_press_s),
    .pressCode (press_code_s)
  );

  assign pause_press_s = key_press_s && (press_code_s == KEY_PAUSE);
  assign gameState     = state_r;

  // Game sequencing; the timer is loaded with N-1 on entry so each timed phase spans exactly N cycles
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r         <= ST_START;
      level           <= '0;
      lives           <= LIVES_START;
      timer_r         <= '0;
      respawnPulse    <= 1'b0;
      levelStartPulse <= 1'b0;
    end else begin
      respawnPulse    <= 1'b0;
      levelStartPulse <= 1'b0;
      case (state_r)
        ST_START, ST_GAMEOVER: begin
          if (key_press_s) begin
            state_r         <= ST_PLAY;
            lives           <= LIVES_START;
            level           <= '0;
            levelStartPulse <= 1'b1;
          end
        end
        ST_PLAY: begin
          if (playerDead) begin
            if (lives <= 4'd1) begin
              state_r <= ST_GAMEOVER;
              lives   <= 4'd0;
            end else begin
              state_r <= ST_RESPAWN;
              lives   <= lives - 4'd1;
              timer_r <= RESPAWN_LOAD;
            end
          end else if (levelComplete) begin
            if (level >= LAST_LEVEL) begin
              state_r <= ST_WIN;
            end else begin
              state_r <= ST_LEVEL_XFER;
              timer_r <= XFER_LOAD;
            end
          end else if (pause_press_s) begin
            state_r <= ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (pause_press_s) begin
            state_r <= ST_PLAY;
          end
        end
        ST_RESPAWN: begin
          if (timer_r == '0) begin
            state_r      <= ST_PLAY;
            respawnPulse <= 1'b1;
          end else begin
            timer_r <= timer_r - TIMER_W'(1);
          end
        end
        ST_LEVEL_XFER: begin
          if (timer_r == '0) begin
            state_r         <= ST_PLAY;
            levelStartPulse <= 1'b1;
            if (level < LAST_LEVEL) begin
              level <= level + LEVEL_W'(1);
            end
          end else begin
            timer_r <= timer_r - TIMER_W'(1);
          end
        end
        ST_WIN: begin
          if (key_press_s) begin
            state_r <= ST_START;
          end
        end
        default: begin
          state_r <= ST_START;
        end
      endcase
    end
  end

endmodule
